// File: rtl/lamp_bus_pkg.sv
// Shared types and constants for the lamp-driver bus controller.
// The optional read path is enabled by defining LAMP_BUS_READ_EN.
package lamp_bus_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int BUS_ADDR_W = 3;
    localparam int NUM_REQ    = 2;
    localparam int CNT_W      = 8;

    localparam logic REQ_CMD     = 1'b0;
    localparam logic REQ_REFRESH = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t INIT   = 3'd0;
    localparam state_t IDLE   = 3'd1;
    localparam state_t SETUP  = 3'd2;
    localparam state_t STROBE = 3'd3;
    localparam state_t HOLD   = 3'd4;

endpackage

// File: rtl/lamp_bus_arbiter.sv
// Two-way round-robin grant: the requester served last loses ties,
// and the pointer starts out favouring the command path.
module lamp_bus_arbiter
    import lamp_bus_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               handshake,
    output logic               grant
);

    logic prio_reg;

    // Favoured requester wins if valid, otherwise fall over to the other one.
    always_comb begin
        grant = prio_reg;
        if (!req_valid[prio_reg]) begin
            grant = ~prio_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_reg <= REQ_CMD;
        end else if (handshake) begin
            prio_reg <= ~grant;
        end
    end

endmodule

// File: rtl/lamp_bus_controller.sv
// Sequences setup/strobe/hold cycles on the lamp-driver bus for two requesters
// and owns lamp power-up reset. Define LAMP_BUS_READ_EN to enable read cycles.
module lamp_bus_controller
    import lamp_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 3,
    parameter int unsigned STROBE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 3,
    parameter int unsigned RESET_CYCLES  = 100
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*BUS_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*BUS_DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_test,
    output logic                          rsp_valid,
    output logic                          rsp_id,
    output logic [BUS_DATA_W-1:0]         rsp_data,
    output logic [BUS_DATA_W-1:0]         bus_data_out,
    input  logic [BUS_DATA_W-1:0]         bus_data_in,
    output logic                          bus_data_drive,
    output logic [BUS_ADDR_W-1:0]         bus_addr,
    output logic                          bus_test,
    output logic                          bus_rd,
    output logic                          bus_wr,
    output logic                          lamp_reset,
    output logic                          oe,
    output logic                          busy
);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [BUS_ADDR_W-1:0]   addr_reg;
    logic [BUS_DATA_W-1:0]   data_out_reg;
    logic                    drive_reg;
    logic                    test_reg;
    logic                    write_reg;
    logic                    id_reg;
    logic                    rsp_valid_reg;
    logic                    rsp_id_reg;
    logic                    grant;
    logic                    accept;
    logic                    write_next;

    logic [BUS_ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [BUS_DATA_W-1:0]   data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*BUS_ADDR_W +: BUS_ADDR_W];
            assign data_arr[gi]  = req_data[gi*BUS_DATA_W +: BUS_DATA_W];
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign accept = |req_ready;

    lamp_bus_arbiter u_arbiter (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .handshake (accept),
        .grant     (grant)
    );

`ifdef LAMP_BUS_READ_EN
    logic [BUS_DATA_W-1:0] rsp_data_reg;

    assign write_next = req_write[grant];
    assign bus_rd     = (state_reg == STROBE) && !write_reg;
    assign rsp_data   = rsp_data_reg;

    // Pins are sampled on the final strobe cycle, when the lamp board data is settled.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_data_reg <= '0;
        end else if (state_reg == STROBE && cnt_reg == STROBE_LAST) begin
            rsp_data_reg <= write_reg ? '0 : bus_data_in;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{bus_data_in, req_write};
    assign write_next  = 1'b1;
    assign bus_rd      = 1'b0;
    assign rsp_data    = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            data_out_reg  <= '0;
            drive_reg     <= 1'b0;
            test_reg      <= 1'b1;
            write_reg     <= 1'b1;
            id_reg        <= REQ_CMD;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= REQ_CMD;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    if (cnt_reg == RESET_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= addr_arr[grant];
                        data_out_reg <= data_arr[grant];
                        test_reg     <= req_test[grant];
                        write_reg    <= write_next;
                        drive_reg    <= write_next;
                        id_reg       <= grant;
                        cnt_reg      <= '0;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        state_reg <= STROBE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_reg == STROBE_LAST) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= '0;
                        drive_reg     <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= id_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= INIT;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus_addr       = addr_reg;
    assign bus_data_out   = data_out_reg;
    assign bus_data_drive = drive_reg;
    assign bus_test       = test_reg;
    assign bus_wr         = (state_reg == STROBE) && write_reg;
    assign lamp_reset     = (state_reg == INIT);
    assign oe             = (state_reg != INIT);
    assign busy           = (state_reg != IDLE);
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_id         = rsp_id_reg;

endmodule

// File: doc/lamp_bus_controller.md
# lamp_bus_controller

Sequences read/write cycles on the 8-bit parallel lamp-driver bus (data, 3-bit address, test-address, RD/WR strobes, lamp reset, level-shifter OE). Two requesters share the bus: port 0 is the UART command path (`pb_i_write,` and friends), port 1 is the periodic lamp refresh scanner. Sits between the command FSM and the pins; owns power-up reset sequencing of the lamp hardware.

## Interface
- `SETUP_CYCLES`, 3: cycles address/data are stable before strobe (1..255)
- `STROBE_CYCLES`, 8: cycles RD/WR strobe is high (1..255)
- `HOLD_CYCLES`, 3: cycles address/data are held after strobe falls (1..255)
- `RESET_CYCLES`, 100: cycles lamp reset is held after `reset` (1..255)

- `clock`  in  1  system clock, 27 MHz
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  request per requester; held until accepted
- `req_ready`  out  2  accept strobe; at most one bit set
- `req_write`  in  2  1 = write, 0 = read, per requester
- `req_addr`  in  6  `req_addr[3*i +: 3]` = address of requester i
- `req_data`  in  16  `req_data[8*i +: 8]` = write data of requester i
- `req_test`  in  2  value driven on `bus_test` for the cycle
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_id`  out  1  requester that owned the completed cycle
- `rsp_data`  out  8  read data; 0 for writes
- `bus_data_out`  out  8  to data pins
- `bus_data_in`  in  8  from data pins
- `bus_data_drive`  out  1  1 = controller drives data pins
- `bus_addr`  out  3; `bus_test`  out  1; `bus_rd`  out  1; `bus_wr`  out  1 (strobes active-high)
- `lamp_reset`  out  1; `oe`  out  1; `busy`  out  1 (high whenever state ≠ IDLE)

## Operation
- States: INIT → IDLE → SETUP → STROBE → HOLD → IDLE.
- INIT: `lamp_reset`=1, `oe`=0, strobes 0, counts `RESET_CYCLES`; then `lamp_reset`=0, `oe`=1, go IDLE.
- IDLE: round-robin grant among valid requesters; requester last served has lower priority; pointer resets to favour requester 0. `req_ready[g]` = IDLE && `req_valid[g]` && grant==g (combinational). On handshake, latch addr/data/write/test/id, go SETUP.
- SETUP: drive `bus_addr`, `bus_test`, `bus_data_out`; `bus_data_drive`=write. STROBE: `bus_wr`=write or `bus_rd`=!write; read data registered on last STROBE cycle. HOLD: strobes low, addr/data/drive unchanged.
- HOLD→IDLE: `rsp_valid`=1 for one cycle with `rsp_id`, `rsp_data`. `bus_data_drive` drops to 0 on entering IDLE; `bus_addr`/`bus_data_out` keep last values.
- Requester may drop `req_valid` before accept; no cycle issued.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `bus_data_out`=0, `bus_data_drive`=0, `bus_addr`=0, `bus_test`=1, `bus_rd`=0, `bus_wr`=0, `lamp_reset`=1, `oe`=0, `busy`=1.
- Handshake in cycle 0 → SETUP cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, `rsp_valid` in cycle S+T+H+1 (defaults: 15).
- New handshake allowed in the `rsp_valid` cycle; back-to-back period S+T+H+1.
- Both valid in same IDLE cycle: one granted per rule above, other waits; never both ready.
- `reset` mid-cycle: strobes low next edge, transaction dropped, no `rsp_valid`, re-enter INIT.
- Counters 8-bit; phase ends when counter == parameter−1.

## Configuration
- `LAMP_BUS_READ_EN` defined: read cycles as above.
- Undefined: `req_write` ignored, every cycle is a write; `bus_rd` constant 0; `rsp_data` constant 0; `bus_data_in` unused. Timing identical.

## Structure
- Package `lamp_bus_pkg`: state typedef (INIT, IDLE, SETUP, STROBE, HOLD), requester id constants (`REQ_CMD`=0, `REQ_REFRESH`=1), bus width constants.
- Sub-module `lamp_bus_arbiter`: 2-way round-robin grant with pointer update on handshake.

## Test plan
- Reset release → `lamp_reset`=1, `oe`=0 for 100 cycles, then 0/1; `busy` falls.
- Port 0 write addr 5 data 0xA5 → `bus_wr` high cycles 4..11, addr 5/data 0xA5/drive 1 cycles 1..14, `rsp_valid` cycle 15, id 0.
- Port 1 read addr 2, `bus_data_in`=0x3C during strobe (macro on) → `bus_rd` pulse 8 cycles, drive 0, `rsp_data`=0x3C, id 1; macro off → write cycle, `rsp_data`=0.
- Both ports valid continuously → grants alternate 0,1,0,1; completions every 15 cycles.
- `reset` asserted during STROBE → strobes 0 next cycle, no `rsp_valid`, INIT sequence repeats.
